// File: rtl/crc16_frame_tx.sv
// rtl/crc16_frame_tx.sv - forwards 16-bit frame words and appends a CRC-16/CCITT-FALSE trailer word
`timescale 1ns/1ps
module crc16_frame_tx #(
    parameter int LEN_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din_valid,
    input  logic [15:0]      i_din,
    input  logic             i_din_last,
    output logic             o_din_ready,
    output logic             o_dout_valid,
    output logic [15:0]      o_dout,
    output logic             o_dout_last,
    output logic             o_dout_is_crc,
    input  logic             i_dout_ready,
    output logic             o_frame_done,
    output logic [LEN_W-1:0] o_frame_words
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CRC  = 2'd2;

    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [15:0]      CRC_POLY = 16'h1021;
    localparam logic [LEN_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state;
    logic [15:0]      crc;
    logic [LEN_W-1:0] cnt;
    logic             out_free;
    logic             in_fire;
    logic             out_fire;
    logic [15:0]      crc_upd;

    // MSB-first CRC update over one word; unrolls into the parallel XOR network
    function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    // Output register is free when empty or being drained this cycle
    assign out_free    = !o_dout_valid || i_dout_ready;
    assign o_din_ready = (state != S_CRC) && out_free;
    assign in_fire     = i_din_valid && o_din_ready;
    assign out_fire    = o_dout_valid && i_dout_ready;

    // First word of a frame starts from the init value regardless of the held crc
    assign crc_upd = crc16_word((state == S_IDLE) ? CRC_INIT : crc, i_din);

    // Frame state, running CRC and saturating word counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            crc   <= CRC_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        crc   <= crc_upd;
                        cnt   <= {{(LEN_W-1){1'b0}}, 1'b1};
                        state <= i_din_last ? S_CRC : S_DATA;
                    end
                end
                S_DATA: begin
                    if (in_fire) begin
                        crc <= crc_upd;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (i_din_last) begin
                            state <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (out_free) begin
                        crc   <= CRC_INIT;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    crc   <= CRC_INIT;
                end
            endcase
        end
    end

    // Single output register: CRC load, data pass-through, or drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dout_valid  <= 1'b0;
            o_dout        <= 16'h0000;
            o_dout_last   <= 1'b0;
            o_dout_is_crc <= 1'b0;
        end else if ((state == S_CRC) && out_free) begin
            o_dout_valid  <= 1'b1;
            o_dout        <= crc;
            o_dout_last   <= 1'b1;
            o_dout_is_crc <= 1'b1;
        end else if (in_fire) begin
            o_dout_valid  <= 1'b1;
            o_dout        <= i_din;
            o_dout_last   <= 1'b0;
            o_dout_is_crc <= 1'b0;
        end else if (out_fire) begin
            o_dout_valid  <= 1'b0;
        end
    end

    // Completion pulse and word count latch when the CRC word leaves
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_done  <= 1'b0;
            o_frame_words <= '0;
        end else if (out_fire && o_dout_is_crc) begin
            o_frame_done  <= 1'b1;
            o_frame_words <= cnt;
        end else begin
            o_frame_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc16_frame_tx.sv
// tb/tb_crc16_frame_tx.sv - scoreboard bench for crc16_frame_tx with byte-table CRC reference model
`timescale 1ns/1ps
module tb_crc16_frame_tx;

    localparam int LW   = 4;
    localparam int CMAX = (1 << LW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_din_valid = 1'b0;
    logic [15:0]   i_din = 16'h0000;
    logic          i_din_last = 1'b0;
    logic          o_din_ready;
    logic          o_dout_valid;
    logic [15:0]   o_dout;
    logic          o_dout_last;
    logic          o_dout_is_crc;
    logic          i_dout_ready = 1'b1;
    logic          o_frame_done;
    logic [LW-1:0] o_frame_words;

    crc16_frame_tx #(.LEN_W(LW)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_din_valid   (i_din_valid),
        .i_din         (i_din),
        .i_din_last    (i_din_last),
        .o_din_ready   (o_din_ready),
        .o_dout_valid  (o_dout_valid),
        .o_dout        (o_dout),
        .o_dout_last   (o_dout_last),
        .o_dout_is_crc (o_dout_is_crc),
        .i_dout_ready  (i_dout_ready),
        .o_frame_done  (o_frame_done),
        .o_frame_words (o_frame_words)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passed = 0;

    logic [15:0] tbl [256];
    logic [15:0] frm [$];
    logic [17:0] exp_q [$];
    int          fw_q [$];

    bit          rnd_ready = 1'b0;
    bit          rst_window = 1'b0;
    int          rst_viol = 0;
    bit          bb_active = 1'b0;
    int          bb_low = 0;
    int          bb_outs = 0;
    int          bb_first = 0;
    int          bb_last = 0;
    int          cyc = 0;
    logic [15:0] last_crc = 16'h0000;
    bit          hold_prev = 1'b0;
    logic [17:0] prev_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference CRC: byte-wise table method over the frame as big-endian bytes
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        foreach (frm[i]) begin
            b = frm[i][15:8];
            c = {c[7:0], 8'h00} ^ tbl[c[15:8] ^ b];
            b = frm[i][7:0];
            c = {c[7:0], 8'h00} ^ tbl[c[15:8] ^ b];
        end
        return c;
    endfunction

    // Downstream ready: held high or random, changed just after the clock edge
    always @(posedge i_clk) begin
        #1;
        i_dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compare every output handshake and frame_done against the scoreboard
    always @(negedge i_clk) begin
        cyc++;
        if (i_rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(o_dout_valid), 32'd1);
                chk("hold_word", 32'({o_dout_is_crc, o_dout_last, o_dout}), 32'(prev_word));
            end
            if (bb_active && bb_outs < 7 && !o_din_ready) bb_low++;
            if (o_dout_valid && i_dout_ready) begin
                if (rst_window) begin
                    if (o_dout_is_crc) rst_viol++;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("out_word", 32'({o_dout_is_crc, o_dout_last, o_dout}), 32'(exp_q.pop_front()));
                end
                if (o_dout_is_crc) last_crc = o_dout;
                if (bb_active) begin
                    bb_outs++;
                    if (bb_outs == 1) bb_first = cyc;
                    if (bb_outs == 7) bb_last = cyc;
                end
            end
            if (o_frame_done) begin
                if (rst_window) begin
                    rst_viol++;
                end else if (fw_q.size() == 0) begin
                    chk("unexpected_done", 32'(fw_q.size()), 32'd1);
                end else begin
                    chk("frame_words", 32'(o_frame_words), 32'(fw_q.pop_front()));
                end
            end
            hold_prev = o_dout_valid && !i_dout_ready;
            prev_word = {o_dout_is_crc, o_dout_last, o_dout};
        end
    end

    // Drive one word and wait for it to be accepted (called at posedge+1)
    task automatic drive_word(input logic [15:0] w, input logic last);
        bit got;
        int guard;
        i_din       = w;
        i_din_last  = last;
        i_din_valid = 1'b1;
        got   = 1'b0;
        guard = 0;
        while (!got && guard < 500) begin
            @(negedge i_clk);
            got = o_din_ready;
            @(posedge i_clk);
            #1;
            guard++;
        end
        if (!got) chk("din_accept_timeout", 32'(guard), 32'd0);
    endtask

    // Issue frm as one frame, pushing the expected output words first
    task automatic send_frame(input bit gaps, input bit zero_crc);
        logic [15:0] c;
        int n;
        n = frm.size();
        c = zero_crc ? 16'h0000 : model_crc();
        foreach (frm[i]) exp_q.push_back({2'b00, frm[i]});
        exp_q.push_back({2'b11, c});
        fw_q.push_back((n > CMAX) ? CMAX : n);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_din_valid = 1'b0;
                @(posedge i_clk);
                #1;
            end
            drive_word(frm[i], i == n - 1);
        end
        i_din_valid = 1'b0;
        i_din_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || fw_q.size() != 0) && guard < 3000) begin
            @(negedge i_clk);
            guard++;
        end
        @(negedge i_clk);
        @(negedge i_clk);
        if (exp_q.size() != 0 || fw_q.size() != 0) chk("drain_timeout", 32'(exp_q.size() + fw_q.size()), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic rand_frame(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(16'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 256; b++) begin
            logic [15:0] c;
            c = 16'(b) << 8;
            for (int k = 0; k < 8; k++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
            tbl[b] = c;
        end

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_dout_valid", 32'(o_dout_valid), 32'd0);
        chk("rst_dout", 32'(o_dout), 32'd0);
        chk("rst_dout_last", 32'(o_dout_last), 32'd0);
        chk("rst_dout_is_crc", 32'(o_dout_is_crc), 32'd0);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
        chk("rst_frame_words", 32'(o_frame_words), 32'd0);
        chk("rst_din_ready", 32'(o_din_ready), 32'd1);
        @(posedge i_clk);
        #1;

        // Single zero word, then feed the emitted frame back in
        frm.delete();
        frm.push_back(16'h0000);
        chk("model_1d0f", 32'(model_crc()), 32'h1D0F);
        send_frame(1'b0, 1'b0);
        drain();
        chk("crc_1d0f", 32'(last_crc), 32'h1D0F);
        frm.push_back(last_crc);
        send_frame(1'b0, 1'b1);
        drain();
        chk("residue_single", 32'(last_crc), 32'h0000);

        // Back-to-back 3- and 2-word frames with valid held high
        bb_active = 1'b1;
        rand_frame(3);
        send_frame(1'b0, 1'b0);
        rand_frame(2);
        send_frame(1'b0, 1'b0);
        drain();
        bb_active = 1'b0;
        chk("bb_outs", 32'(bb_outs), 32'd7);
        chk("bb_span", 32'(bb_last - bb_first), 32'd6);
        chk("bb_ready_low", 32'(bb_low), 32'd2);

        // Random backpressure and input gaps, frames streamed without draining
        rnd_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rand_frame($urandom_range(1, 64));
            send_frame(1'b1, 1'b0);
        end
        drain();

        // Random loopback: every CRC-appended frame must leave a zero residue
        for (int f = 0; f < 100; f++) begin
            rnd_ready = f[0];
            rand_frame($urandom_range(1, 64));
            send_frame(1'b1, 1'b0);
            drain();
            frm.push_back(last_crc);
            send_frame(1'b1, 1'b1);
            drain();
        end
        rnd_ready = 1'b0;

        // Reset after two words of a five-word frame
        rst_window = 1'b1;
        rand_frame(5);
        drive_word(frm[0], 1'b0);
        drive_word(frm[1], 1'b0);
        i_din_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_valid", 32'(o_dout_valid), 32'd0);
        repeat (10) @(posedge i_clk);
        #1;
        rst_window = 1'b0;
        chk("rst_mid_no_crc_done", 32'(rst_viol), 32'd0);
        frm.delete();
        frm.push_back(16'h0000);
        send_frame(1'b0, 1'b0);
        drain();
        chk("after_rst_crc", 32'(last_crc), 32'h1D0F);

        // Counter saturation around the 4-bit limit
        rand_frame(20);
        send_frame(1'b0, 1'b0);
        rand_frame(15);
        send_frame(1'b0, 1'b0);
        rand_frame(16);
        send_frame(1'b0, 1'b0);
        drain();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("fw_q_empty", 32'(fw_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
